// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiplier control unit and datapath.
// Control bit indices, Booth recoding pairs, default sizes and the control-word decoder.
package booth_pkg;

  localparam int WIDTH_DEF        = 8;
  localparam int COUNTER_BITS_DEF = 3;

  localparam int C_INIT   = 0;
  localparam int C_LOAD_Q = 1;
  localparam int C_ADDSUB = 2;
  localparam int C_SUB    = 3;
  localparam int C_SHIFT  = 4;
  localparam int C_OUT_HI = 5;
  localparam int C_OUT_LO = 6;
  localparam int C_RSVD   = 7;

  localparam logic [1:0] PAIR_ADD = 2'b01;
  localparam logic [1:0] PAIR_SUB = 2'b10;

  typedef logic [7:0] ctrl_t;

  // Which state-changing micro-operation wins this cycle; c5/c6 are decoded separately.
  typedef enum logic [1:0] {
    OP_HOLD   = 2'd0,
    OP_INIT   = 2'd1,
    OP_LOAD_Q = 2'd2,
    OP_EXEC   = 2'd3
  } dp_op_e;

  function automatic dp_op_e decode_op(input ctrl_t c);
    dp_op_e op;
    op = OP_HOLD;
    if (c[C_INIT])
      op = OP_INIT;
    else if (c[C_LOAD_Q])
      op = OP_LOAD_Q;
    else if (c[C_ADDSUB] || c[C_SHIFT])
      op = OP_EXEC;
    return op;
  endfunction

endpackage

// File: rtl/booth_datapath_if.sv
// Controller-to-datapath bus: micro-op word and operand in, Booth status and result out.
// Master is the control unit / operand source, slave is the datapath.
interface booth_datapath_if
  import booth_pkg::*;
#(
  parameter int WIDTH        = WIDTH_DEF,
  parameter int COUNTER_BITS = COUNTER_BITS_DEF
);

  ctrl_t                   control;
  logic [WIDTH-1:0]        inbus;
  logic [1:0]              q_reg;
  logic [COUNTER_BITS-1:0] counter_out;
  logic [WIDTH-1:0]        outbus;
  logic                    outbus_valid;

  modport master (
    output control,
    output inbus,
    input  q_reg,
    input  counter_out,
    input  outbus,
    input  outbus_valid
  );

  modport slave (
    input  control,
    input  inbus,
    output q_reg,
    output counter_out,
    output outbus,
    output outbus_valid
  );

endinterface

// File: rtl/booth_addsub.sv
// Combinational N-bit adder/subtractor (two's complement, carry-out dropped).
// Zero latency, no backpressure.
module booth_addsub #(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] sum
);

  logic [N-1:0] b_eff;
  logic [N-1:0] cin;

  always_comb begin
    b_eff = sub ? ~b : b;
    cin   = {{(N-1){1'b0}}, sub};
    sum   = a + b_eff + cin;
  end

endmodule

// File: rtl/booth_datapath.sv
// Radix-2 Booth datapath: M/A/Q/Q-1 registers and shift counter driven by the control word.
// Updates on the sampling edge, result word one cycle after c5/c6; no backpressure.
module booth_datapath
  import booth_pkg::*;
#(
  parameter int WIDTH        = WIDTH_DEF,
  parameter int COUNTER_BITS = COUNTER_BITS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  booth_datapath_if.slave   bus
);

  logic [WIDTH-1:0]        mcand;
  logic [WIDTH:0]          acc;
  logic [WIDTH-1:0]        mplier;
  logic                    q_m1;
  logic [COUNTER_BITS-1:0] cnt;
  logic [WIDTH-1:0]        out_word;
  logic                    out_vld;

  ctrl_t                   ctl;
  dp_op_e                  op;
  logic [WIDTH:0]          a_sum;
  logic [WIDTH:0]          a_next;
  logic [2*WIDTH+1:0]      aqq;
  logic [2*WIDTH+1:0]      aqq_shr;
  logic                    unused_rsvd;

  assign ctl         = bus.control;
  assign op          = decode_op(ctl);
  assign unused_rsvd = ctl[C_RSVD];

  // A carries one guard bit so that subtracting M = -2^(WIDTH-1) cannot overflow.
  booth_addsub #(.N(WIDTH + 1)) u_addsub (
    .a   (acc),
    .b   ({mcand[WIDTH-1], mcand}),
    .sub (ctl[C_SUB]),
    .sum (a_sum)
  );

  always_comb begin
    a_next  = ctl[C_ADDSUB] ? a_sum : acc;
    aqq     = {a_next, mplier, q_m1};
    aqq_shr = {aqq[2*WIDTH+1], aqq[2*WIDTH+1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand    <= '0;
      acc      <= '0;
      mplier   <= '0;
      q_m1     <= 1'b0;
      cnt      <= '0;
      out_word <= '0;
      out_vld  <= 1'b0;
    end else begin
      unique case (op)
        OP_INIT: begin
          mcand <= bus.inbus;
          acc   <= '0;
          q_m1  <= 1'b0;
          cnt   <= '0;
        end
        OP_LOAD_Q: begin
          mplier <= bus.inbus;
        end
        OP_EXEC: begin
          // With c2|c4 together the shift consumes the add/sub result in one cycle.
          if (ctl[C_SHIFT]) begin
            acc    <= aqq_shr[2*WIDTH+1:WIDTH+1];
            mplier <= aqq_shr[WIDTH:1];
            q_m1   <= aqq_shr[0];
            cnt    <= cnt + 1'b1;
          end else begin
            acc <= a_next;
          end
        end
        default: begin
        end
      endcase

      // Captures see pre-update register values; c5 beats c6.
      if (ctl[C_OUT_HI]) begin
        out_word <= acc[WIDTH-1:0];
        out_vld  <= 1'b1;
      end else if (ctl[C_OUT_LO]) begin
        out_word <= mplier;
        out_vld  <= 1'b1;
      end else begin
        out_vld  <= 1'b0;
      end
    end
  end

  assign bus.q_reg        = {mplier[0], q_m1};
  assign bus.counter_out  = cnt;
  assign bus.outbus       = out_word;
  assign bus.outbus_valid = out_vld;

endmodule

// File: tb/tb_booth_datapath.sv
// Self-checking bench for booth_datapath: table-driven multiplies plus hand-written corner sequences.
// Result words are checked by a scoreboard queue filled when c5/c6 is issued.
module tb_booth_datapath;
  import booth_pkg::*;

  logic clk;
  logic rst_n;

  booth_datapath_if #(.WIDTH(8), .COUNTER_BITS(3)) bus ();

  booth_datapath #(.WIDTH(8), .COUNTER_BITS(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] m;
    logic [7:0] q;
    logic [7:0] hi;
    logic [7:0] lo;
  } mul_vec_t;

  mul_vec_t vecs[9];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every outbus_valid pulse must match the oldest expected word.
  always @(negedge clk) begin
    if (bus.outbus_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: outbus_valid=1 outbus=0x%0h, expected no pulse", bus.outbus);
      end else begin
        chk("outbus", int'(bus.outbus), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic drive(input logic [7:0] c, input logic [7:0] d);
    bus.control = c;
    bus.inbus   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic booth_iter();
    logic [7:0] c;
    c = 8'h10;
    if (bus.q_reg == PAIR_ADD)
      c = c | 8'h04;
    else if (bus.q_reg == PAIR_SUB)
      c = c | 8'h0C;
    drive(c, 8'h00);
  endtask

  task automatic do_mul(input int idx, input mul_vec_t v);
    drive(8'h01, v.m);
    drive(8'h02, v.q);
    for (int i = 0; i < 8; i++)
      booth_iter();
    chk($sformatf("counter_wrap[%0d]", idx), int'(bus.counter_out), 0);
    exp_q.push_back(v.hi);
    drive(8'h20, 8'h00);
    exp_q.push_back(v.lo);
    drive(8'h40, 8'h00);
    drive(8'h00, 8'h00);
    drive(8'h00, 8'h00);
    chk($sformatf("sb_drained[%0d]", idx), exp_q.size(), 0);
  endtask

  initial begin
    vecs[0] = '{m: 8'h03, q: 8'hFE, hi: 8'hFF, lo: 8'hFA};
    vecs[1] = '{m: 8'h07, q: 8'h07, hi: 8'h00, lo: 8'h31};
    vecs[2] = '{m: 8'h80, q: 8'h80, hi: 8'h40, lo: 8'h00};
    vecs[3] = '{m: 8'hFF, q: 8'hFF, hi: 8'h00, lo: 8'h01};
    vecs[4] = '{m: 8'h7F, q: 8'h80, hi: 8'hC0, lo: 8'h80};
    vecs[5] = '{m: 8'h00, q: 8'h5A, hi: 8'h00, lo: 8'h00};
    vecs[6] = '{m: 8'h80, q: 8'h7F, hi: 8'hC0, lo: 8'h80};
    vecs[7] = '{m: 8'h80, q: 8'h01, hi: 8'hFF, lo: 8'h80};
    vecs[8] = '{m: 8'h19, q: 8'hF6, hi: 8'hFF, lo: 8'h06};

    bus.control = 8'h00;
    bus.inbus   = 8'h00;
    rst_n       = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_q_reg", int'(bus.q_reg), 0);
    chk("rst_counter", int'(bus.counter_out), 0);
    chk("rst_outbus", int'(bus.outbus), 0);
    chk("rst_valid", int'(bus.outbus_valid), 0);
    rst_n = 1'b1;
    drive(8'h00, 8'h00);

    for (int i = 0; i < 9; i++)
      do_mul(i, vecs[i]);

    // c0|c1 together: INIT only, Q untouched.
    drive(8'h02, 8'hA6);
    drive(8'h03, 8'h05);
    chk("init_counter", int'(bus.counter_out), 0);
    chk("init_q_reg", int'(bus.q_reg), 0);
    exp_q.push_back(8'hA6);
    drive(8'h40, 8'h00);
    drive(8'h04, 8'h00);
    exp_q.push_back(8'h05);
    drive(8'h20, 8'h00);
    drive(8'h02, 8'h01);
    chk("load_q_pair", int'(bus.q_reg), 2);

    // c3 alone, c7 alone and control=0 must leave state alone.
    drive(8'h01, 8'h09);
    drive(8'h02, 8'h33);
    drive(8'h04, 8'h00);
    drive(8'h10, 8'h00);
    chk("shift_q_reg", int'(bus.q_reg), 3);
    chk("shift_counter", int'(bus.counter_out), 1);
    drive(8'h08, 8'h00);
    drive(8'h80, 8'h00);
    drive(8'h00, 8'h00);
    chk("hold_q_reg", int'(bus.q_reg), 3);
    chk("hold_counter", int'(bus.counter_out), 1);
    chk("hold_valid", int'(bus.outbus_valid), 0);
    exp_q.push_back(8'h04);
    drive(8'h30, 8'h00);
    chk("shift_cap_q_reg", int'(bus.q_reg), 1);
    chk("shift_cap_counter", int'(bus.counter_out), 2);
    exp_q.push_back(8'h4C);
    drive(8'h40, 8'h00);
    exp_q.push_back(8'h02);
    drive(8'h60, 8'h00);
    drive(8'h00, 8'h00);
    chk("hand_sb_drained", exp_q.size(), 0);

    // Asynchronous reset partway through a multiply.
    drive(8'h01, 8'h03);
    drive(8'h02, 8'hFE);
    for (int i = 0; i < 4; i++)
      booth_iter();
    chk("mid_counter", int'(bus.counter_out), 4);
    chk("mid_outbus", int'(bus.outbus), 2);
    bus.control = 8'h34;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_q_reg", int'(bus.q_reg), 0);
    chk("arst_counter", int'(bus.counter_out), 0);
    chk("arst_outbus", int'(bus.outbus), 0);
    chk("arst_valid", int'(bus.outbus_valid), 0);
    repeat (2) @(posedge clk);
    #1;
    bus.control = 8'h00;
    rst_n = 1'b1;
    drive(8'h00, 8'h00);
    drive(8'h00, 8'h00);
    chk("post_rst_q_reg", int'(bus.q_reg), 0);
    chk("post_rst_outbus", int'(bus.outbus), 0);
    chk("final_sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/booth_datapath.md
# booth_datapath

Radix-2 Booth multiplier datapath: the responder side of the 8-bit one-hot-style `control` bus driven by the Booth control unit. It holds the multiplicand (M), accumulator (A), multiplier (Q) and Q₋₁ registers, plus the iteration counter. It executes the micro-operations encoded on `control` and returns `q_reg`/`counter_out` as status for the controller's branch decisions. It sits between the operand input bus and the result output bus, below the controller in the multiplier top level.

## Interface

- `WIDTH`, 8 — operand width in bits; product is 2×WIDTH.
- `COUNTER_BITS`, 3 — iteration counter width; WIDTH must equal 2**COUNTER_BITS.
- `clk` input 1 — single clock; all state updates on rising edge.
- `rst_n` input 1 — reset, asynchronous, active-low.
- `control` input 8 — micro-operation word; bit i = ci.
- `inbus` input WIDTH — operand input, sampled on c0/c1.
- `q_reg` output 2 — {Q[0], Q₋₁}, Booth recoding pair.
- `counter_out` output COUNTER_BITS — number of shifts performed (mod 2**COUNTER_BITS).
- `outbus` output WIDTH — registered result word.
- `outbus_valid` output 1 — one-cycle strobe, high while `outbus` carries a freshly captured word.

## Operation

- Registers: M (WIDTH bits), A (WIDTH+1 bits, sign-extended guard bit), Q (WIDTH), Q₋₁ (1), counter (COUNTER_BITS), outbus (WIDTH), outbus_valid (1).
- c0 (INIT): M ← inbus; A ← 0; Q₋₁ ← 0; counter ← 0.
- c1 (LOAD_Q): Q ← inbus.
- c2 (ADDSUB): A ← A + sext(M). With c3 also set: A ← A − sext(M). c3 alone is a no-op.
- c4 (SHIFT): arithmetic right shift of {A, Q, Q₋₁} by one (A[WIDTH] replicated); counter ← counter + 1, wrapping at 2**COUNTER_BITS.
- c2 and c4 in the same cycle: the shift acts on the add/sub result (single-cycle iteration); the counter increments once.
- c5 (OUT_HI): outbus ← A[WIDTH-1:0]; outbus_valid ← 1.
- c6 (OUT_LO): outbus ← Q; outbus_valid ← 1. If c5 and c6 are both set, c5 wins.
- c7: reserved, ignored.
- Precedence among state-changing bits:
  - c0 overrides c1–c4: only INIT happens that cycle.
  - c1 overrides c2–c4: only LOAD_Q happens (plus any c5/c6 capture).
  - c5/c6 are independent of the others and capture pre-update register values.
- control = 0: all registers hold; outbus_valid ← 0.
- Supports M = −2^(WIDTH−1) correctly via the WIDTH+1-bit A.

## Timing

- Reset (rst_n low, asynchronous): A, M, Q, Q₋₁, counter, outbus, outbus_valid all 0; q_reg = 2'b00; counter_out = 0. Reset mid-multiply aborts immediately; no partial result is emitted.
- All micro-operations take effect at the rising edge on which the control bit is sampled high.
- q_reg and counter_out are combinational from registers: valid the cycle after the updating edge, with no further latency.
- outbus/outbus_valid: one-cycle latency from the c5/c6 edge. outbus holds its value until the next capture; outbus_valid is high for exactly one cycle per capture.
- Full multiply using combined c2|c4 steps: 1 (c0) + 1 (c1) + WIDTH iterations + 2 output cycles.

## Structure

- Shared package `booth_pkg`:
  - control bit index constants C_INIT=0, C_LOAD_Q=1, C_ADDSUB=2, C_SUB=3, C_SHIFT=4, C_OUT_HI=5, C_OUT_LO=6, C_RSVD=7;
  - Booth pair constants PAIR_ADD=2'b01, PAIR_SUB=2'b10;
  - default WIDTH/COUNTER_BITS; shared with the control unit.
- One sub-module, `booth_addsub`: combinational (WIDTH+1)-bit adder/subtractor with inputs a, b, sub and output sum. Registers and shifter stay in booth_datapath.

## Test plan

- Reset, then M=3 (c0), Q=0xFE (c1), 8 steps each with c4 set, plus c2 when q_reg=01 or c2|c3 when q_reg=10, then c5, c6 → outbus 0xFF then 0xFA (−6), each with a 1-cycle outbus_valid; counter_out=0 after wrap.
- M=7, Q=7, same driver → outbus 0x00 then 0x31 (49).
- M=0x80, Q=0x80 → outbus 0x40 then 0x00 (16384); exercises the guard bit.
- c0|c1 with inbus=0x05 → M=5, Q unchanged; then c1 with inbus=0x01 → q_reg=2'b10 on the next cycle.
- c3 alone, c7 alone, control=0 → no register changes; outbus_valid stays 0.
- Assert rst_n low asynchronously after 4 iterations → all outputs 0 before the next clock edge; no outbus_valid pulse.
